// File: rtl/rv32i_types.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rv32i_types : shared pipeline types, LSU state encoding and lane masks
// Revision    : 1.0
// -----------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [3:0] MBE_B = 4'b0001;
  localparam logic [3:0] MBE_H = 4'b0011;
  localparam logic [3:0] MBE_W = 4'b1111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic       mem_read_d;
    logic       mem_write_d;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_mem_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    mem_ctrl_t  mem;
    rvfi_mem_t  rvfi;
  } control_word;

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_stage_lsu_if : data-cache request/response bus between LSU and cache
// Revision         : 1.0
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output dmem_rdata, dmem_resp
  );
endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// -----------------------------------------------------------------------------
// load_align : selects the addressed byte/half of a load word and extends it
// Revision   : 1.0
// -----------------------------------------------------------------------------
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  load_funct3,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (off)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    // Halfword loads ignore off[0]; misalignment is not trapped here.
    w_half = off[1] ? rdata[31:16] : rdata[15:0];

    case (load_funct3)
      F3_LB:   data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  data = {24'b0, w_byte};
      F3_LH:   data = {{16{w_half[15]}}, w_half};
      F3_LHU:  data = {16'b0, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_stage_lsu : MEM-stage load/store unit, cache initiator and WB producer
// Revision      : 1.0
// -----------------------------------------------------------------------------
module mem_stage_lsu
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_mem_valid,
  input  control_word         cw_in,
  input  logic [ADDR_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   rs2_data,
  mem_stage_lsu_if.master     dmem,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic                mem_wb_valid,
  output logic                mem_wb_rdy,
  output logic                stall_mem,
  output control_word         cw_out
);

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic              w_memop;
  logic              w_rdy;
  logic [3:0]        w_lanes;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_load;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_q;
  logic [3:0]        r_mbe;
  logic [3:0]        r_rmask;
  logic [2:0]        r_funct3;
  logic              r_mem_read;
  logic              r_mem_write;

  assign w_memop = ex_mem_valid & (cw_in.mem.mem_read_d | cw_in.mem.mem_write_d);

  // Lane pattern is shared by loads (rmask) and stores (mbe).
  always_comb begin
    case (cw_in.mem.funct3[1:0])
      2'b00: begin
        w_lanes     = MBE_B << alu_out[1:0];
        w_wdata_rep = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        w_lanes     = MBE_H << {alu_out[1], 1'b0};
        w_wdata_rep = {2{rs2_data[15:0]}};
      end
      default: begin
        w_lanes     = MBE_W;
        w_wdata_rep = rs2_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_rdy           = 1'b0;
    dmem.dmem_read  = 1'b0;
    dmem.dmem_write = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_next = ACCESS;
        end else begin
          w_rdy = ex_mem_valid;
        end
      end
      ACCESS: begin
        // Registered op type keeps the request alive through a flush.
        dmem.dmem_read  = r_mem_read;
        dmem.dmem_write = r_mem_write;
        if (dmem.dmem_resp) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_rdy  = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_q   <= '0;
      r_mbe       <= '0;
      r_rmask     <= '0;
      r_funct3    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      if (r_state == IDLE && w_memop) begin
        r_addr      <= alu_out;
        r_funct3    <= cw_in.mem.funct3;
        r_mem_read  <= cw_in.mem.mem_read_d;
        r_mem_write <= cw_in.mem.mem_write_d;
        r_mbe       <= cw_in.mem.mem_write_d ? w_lanes : 4'b0000;
        r_rmask     <= cw_in.mem.mem_read_d ? w_lanes : 4'b0000;
        r_wdata     <= cw_in.mem.mem_write_d ? w_wdata_rep : '0;
      end
      if (r_state == ACCESS && dmem.dmem_resp) begin
        r_rdata_q <= dmem.dmem_rdata;
      end
    end
  end

  load_align u_load_align (
    .rdata       (r_rdata_q),
    .off         (r_addr[1:0]),
    .load_funct3 (r_funct3),
    .data        (w_load)
  );

  assign dmem.dmem_address = {r_addr[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_wdata   = r_wdata;
  assign dmem.dmem_mbe     = r_mbe;

  assign mem_data_out = (r_state == DONE && r_mem_read) ? w_load : '0;
  assign mem_wb_valid = ex_mem_valid & ~rst;
  assign mem_wb_rdy   = w_rdy & ~rst;
  assign stall_mem    = w_memop & (r_state != DONE) & ~rst;

  always_comb begin
    cw_out      = cw_in;
    cw_out.rvfi = '0;
    if (w_memop && r_state != IDLE) begin
      cw_out.rvfi.mem_addr  = dmem.dmem_address;
      cw_out.rvfi.rmask     = r_rmask;
      cw_out.rvfi.wmask     = r_mbe;
      cw_out.rvfi.mem_wdata = r_wdata;
      cw_out.rvfi.mem_rdata = r_rdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu : directed + randomized bench for mem_stage_lsu
// Revision         : 1.0
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  control_word cw_in;
  control_word cw_out;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic [31:0] mem_data_out;
  logic        mem_wb_valid;
  logic        mem_wb_rdy;
  logic        stall_mem;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if dmem_if ();

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_valid (ex_mem_valid),
    .cw_in        (cw_in),
    .alu_out      (alu_out),
    .rs2_data     (rs2_data),
    .dmem         (dmem_if),
    .mem_data_out (mem_data_out),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_rdy   (mem_wb_rdy),
    .stall_mem    (stall_mem),
    .cw_out       (cw_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: byte/half picked out by shifting the word, then extended.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] v;
    case (f3)
      F3_LB, F3_LBU: begin
        v = (word >> (8 * off)) & 32'h0000_00ff;
        if (f3 == F3_LB && v >= 32'd128) v = v | 32'hffff_ff00;
      end
      F3_LH, F3_LHU: begin
        v = (word >> ((off >= 2'd2) ? 16 : 0)) & 32'h0000_ffff;
        if (f3 == F3_LH && v >= 32'd32768) v = v | 32'hffff_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_lanes(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return (off >= 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {24'b0, d[7:0]} * 32'h0101_0101;
      2'b01:   return {16'b0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic drive_instr(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
    ex_mem_valid          = v;
    cw_in                 = '0;
    cw_in.rd              = 5'($urandom);
    cw_in.reg_write       = rd;
    cw_in.mem.mem_read_d  = rd;
    cw_in.mem.mem_write_d = wr;
    cw_in.mem.funct3      = f3;
    cw_in.rvfi            = '1;
    alu_out               = a;
    rs2_data              = d;
  endtask

  // All step tasks start and end just after a rising edge.
  task automatic alu_op();
    drive_instr(1'b1, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
    @(negedge clk);
    chk("alu rdy", 32'(mem_wb_rdy), 32'd1);
    chk("alu stall", 32'(stall_mem), 32'd0);
    chk("alu req", {30'b0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
    chk("alu rvfi addr", cw_out.rvfi.mem_addr, 32'd0);
    chk("alu rvfi masks", {24'b0, cw_out.rvfi.rmask, cw_out.rvfi.wmask}, 32'd0);
    chk("alu rd pass", 32'(cw_out.rd), 32'(cw_in.rd));
    @(posedge clk); #1;
  endtask

  task automatic mem_op(input logic is_ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdat, input int waits,
                        input logic flush);
    logic [3:0] lanes;
    int         stalls;
    stalls = 0;
    lanes  = model_lanes(f3, a[1:0]);
    drive_instr(1'b1, is_ld, !is_ld, f3, a, d);
    dmem_if.dmem_resp = 1'b0;
    @(negedge clk);
    chk("arrive rdy", 32'(mem_wb_rdy), 32'd0);
    stalls += int'(stall_mem);
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      if (flush) ex_mem_valid = 1'b0;
      if (i == waits) begin
        dmem_if.dmem_resp  = 1'b1;
        dmem_if.dmem_rdata = rdat;
      end
      @(negedge clk);
      chk("req read", 32'(dmem_if.dmem_read), 32'(is_ld));
      chk("req write", 32'(dmem_if.dmem_write), 32'(!is_ld));
      chk("req addr", dmem_if.dmem_address, {a[31:2], 2'b00});
      if (!is_ld) begin
        chk("req wdata", dmem_if.dmem_wdata, model_store(f3, d));
        chk("req mbe", 32'(dmem_if.dmem_mbe), 32'(lanes));
      end
      chk("access rdy", 32'(mem_wb_rdy), 32'd0);
      stalls += int'(stall_mem);
      @(posedge clk); #1;
      dmem_if.dmem_resp  = 1'b0;
      dmem_if.dmem_rdata = $urandom;
    end
    @(negedge clk);
    chk("done rdy", 32'(mem_wb_rdy), 32'd1);
    chk("done stall", 32'(stall_mem), 32'd0);
    chk("done req", {30'b0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
    chk("done valid", 32'(mem_wb_valid), 32'(!flush));
    chk("done data", mem_data_out, is_ld ? model_load(f3, a[1:0], rdat) : 32'd0);
    if (!flush) begin
      chk("rvfi addr", cw_out.rvfi.mem_addr, {a[31:2], 2'b00});
      chk("rvfi rmask", 32'(cw_out.rvfi.rmask), is_ld ? 32'(lanes) : 32'd0);
      chk("rvfi wmask", 32'(cw_out.rvfi.wmask), is_ld ? 32'd0 : 32'(lanes));
      chk("rvfi rdata", cw_out.rvfi.mem_rdata, rdat);
      if (!is_ld) chk("rvfi wdata", cw_out.rvfi.mem_wdata, model_store(f3, d));
    end
    chk("stall cycles", 32'(stalls), flush ? 32'd1 : 32'(waits + 2));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] ld_f3s [5];
    logic [2:0] st_f3s [3];
    ld_f3s = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    st_f3s = '{F3_SB, F3_SH, F3_SW};

    // Reset state
    rst = 1'b1;
    drive_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_if.dmem_resp  = 1'b0;
    dmem_if.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst valid", 32'(mem_wb_valid), 32'd0);
    chk("rst rdy", 32'(mem_wb_rdy), 32'd0);
    chk("rst stall", 32'(stall_mem), 32'd0);
    chk("rst req", {30'b0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
    chk("rst mbe", 32'(dmem_if.dmem_mbe), 32'd0);
    chk("rst wdata", dmem_if.dmem_wdata, 32'd0);
    chk("rst data", mem_data_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    mem_op(1'b1, F3_LW,  32'h0000_1004, 32'h0, 32'hCAFE_BABE, 2, 1'b0);
    mem_op(1'b1, F3_LB,  32'h0000_2003, 32'h0, 32'h80FF_0000, 0, 1'b0);
    mem_op(1'b1, F3_LBU, 32'h0000_2003, 32'h0, 32'h80FF_0000, 1, 1'b0);
    mem_op(1'b0, F3_SH,  32'h0000_3002, 32'h1234_ABCD, 32'h0, 3, 1'b0);
    mem_op(1'b1, F3_LHU, 32'h0000_4001, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    alu_op();
    mem_op(1'b0, F3_SW,  32'h0000_5000, 32'h0BAD_F00D, 32'h0, 0, 1'b0);
    alu_op();
    mem_op(1'b0, F3_SB,  32'h0000_6001, 32'h0000_00A5, 32'h0, 2, 1'b1);

    // Reset while a read is outstanding; the late response must be ignored
    drive_instr(1'b1, 1'b1, 1'b0, F3_LW, 32'h0000_7000, 32'h0);
    @(posedge clk); #1;
    rst          = 1'b1;
    ex_mem_valid = 1'b0;
    @(posedge clk); #1;
    rst                = 1'b0;
    dmem_if.dmem_resp  = 1'b1;
    dmem_if.dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rst mid read", 32'(dmem_if.dmem_read), 32'd0);
    chk("rst mid rdy", 32'(mem_wb_rdy), 32'd0);
    chk("rst mid data", mem_data_out, 32'd0);
    @(posedge clk); #1;
    dmem_if.dmem_resp = 1'b0;
    @(negedge clk);
    chk("late resp rdy", 32'(mem_wb_rdy), 32'd0);
    chk("late resp data", mem_data_out, 32'd0);
    @(posedge clk); #1;
    mem_op(1'b1, F3_LH, 32'h0000_8002, 32'h0, 32'h8001_7FFF, 0, 1'b0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: alu_op();
        1: mem_op(1'b1, ld_f3s[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), 1'b0);
        default: mem_op(1'b0, st_f3s[$urandom_range(0, 2)], $urandom, $urandom, $urandom,
                        int'($urandom_range(0, 3)), 1'b0);
      endcase
    end

    ex_mem_valid = 1'b0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
